// File: rtl/store_issue_buf.sv
// store_issue_buf
//
// Write-side companion to the writeback load extraction. It takes committed
// SB/SH/SW stores from the mem stage and formats each one into byte strobes
// and lane-replicated write data. The formatted stores are queued in a small
// in-order FIFO. They are drained one at a time over an SRAM-like interface
// (req / addr_ok / data_ok), with at most one transaction outstanding.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   st_valid        mem stage presents a store
//   st_ready        buffer has room (registered count < DEPTH)
//   st_addr         byte address of the store
//   st_wdata        rt value, unshifted
//   st_size         0 = byte, 1 = half, 2 = word, 3 = illegal
//   st_ades         combinational misaligned/illegal flag for the presented store
//   data_req        request valid toward the bridge
//   data_wr         write flag, mirrors data_req
//   data_size       head entry size
//   data_addr       head entry address (unmodified)
//   data_wstrb      head entry byte strobes
//   data_wdata      head entry lane-aligned data
//   data_addr_ok    slave accepted the request
//   data_data_ok    slave completed the write
//   ld_addr         address of the load currently in mem
//   ld_hit          some queued or in-flight store touches the same word
//   sb_empty        nothing queued and nothing in flight
module store_issue_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_wdata,
    input  logic [1:0]    st_size,
    output logic          st_ades,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [3:0]    data_wstrb,
    output logic [31:0]   data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic          sb_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    function automatic logic ades_chk(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'd0:    ades_chk = 1'b0;
            2'd1:    ades_chk = ofs[0];
            2'd2:    ades_chk = (ofs != 2'd0);
            default: ades_chk = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] fmt_strb(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'd0:    fmt_strb = 4'b0001 << ofs;
            2'd1:    fmt_strb = ofs[1] ? 4'b1100 : 4'b0011;
            2'd2:    fmt_strb = 4'b1111;
            default: fmt_strb = 4'b0000;
        endcase
    endfunction

    // Replicating the low bytes across all lanes lets the strobes alone pick the
    // destination lane, so no shifter is needed.
    function automatic logic [31:0] fmt_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    fmt_data = {4{wd[7:0]}};
            2'd1:    fmt_data = {2{wd[15:0]}};
            default: fmt_data = wd;
        endcase
    endfunction

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          enq;
    logic          pop;

    logic [AW-1:0] ent_addr [DEPTH];
    logic [1:0]    ent_size [DEPTH];
    logic [3:0]    ent_strb [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [PW-1:0] ent_ofs  [DEPTH];
    logic [DEPTH-1:0] ent_vld;

    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

    assign st_ades  = ades_chk(st_size, st_addr[1:0]);
    assign st_ready = (count < CW'(DEPTH));
    assign enq      = st_valid && st_ready && !st_ades;
    assign pop      = ((state == S_REQ) && data_addr_ok && data_data_ok) ||
                      ((state == S_WAIT) && data_data_ok);

    always_comb begin
        case ({enq, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Entry payload carries no reset; validity comes from count/rd_ptr only.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[wr_ptr] <= st_addr;
            ent_size[wr_ptr] <= st_size;
            ent_strb[wr_ptr] <= fmt_strb(st_size, st_addr[1:0]);
            ent_data[wr_ptr] <= fmt_data(st_size, st_wdata);
        end
    end

    // Next state is decided on count_nxt so that an enqueue into an empty
    // buffer, or an enqueue racing a final pop, is issued on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case (state)
                S_IDLE: begin
                    if (count_nxt != '0) state <= S_REQ;
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        if (!data_data_ok)         state <= S_WAIT;
                        else if (count_nxt != '0)  state <= S_REQ;
                        else                       state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) state <= (count_nxt != '0) ? S_REQ : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign data_req   = (state == S_REQ);
    assign data_wr    = data_req;
    assign data_addr  = data_req ? ent_addr[rd_ptr] : '0;
    assign data_size  = data_req ? ent_size[rd_ptr] : 2'd0;
    assign data_wstrb = data_req ? ent_strb[rd_ptr] : 4'd0;
    assign data_wdata = data_req ? ent_data[rd_ptr] : 32'd0;

    // Entry i is live when its distance from the head is below count.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_ofs[i] = PW'(i) - rd_ptr;
            ent_vld[i] = ({1'b0, ent_ofs[i]} < count);
            if (ent_vld[i] && (ent_addr[i][AW-1:2] == ld_addr[AW-1:2])) ld_hit = 1'b1;
        end
    end

    assign sb_empty = (count == '0) && (state == S_IDLE);

endmodule

// File: tb/tb_store_issue_buf.sv
// Directed bench for store_issue_buf: a vector table for formatting and
// misalignment, plus hand sequences for backpressure, ordering, the
// addr_ok/data_ok race, load hit detection and reset mid-transaction.
module tb_store_issue_buf;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [1:0]  st_size;
    logic        st_ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        sb_empty;

    int checks;
    int errors;

    store_issue_buf #(.DEPTH(4), .AW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_wdata     (st_wdata),
        .st_size      (st_size),
        .st_ades      (st_ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .sb_empty     (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic        ades;
        logic [3:0]  strb;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic present(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        st_valid = 1'b1;
        st_addr  = a;
        st_size  = sz;
        st_wdata = wd;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{32'h0000_1003, 2'd0, 32'hAABB_CCDD, 1'b0, 4'b1000, 32'hDDDD_DDDD};
        vecs[1] = '{32'h0000_2001, 2'd1, 32'h0000_1234, 1'b1, 4'b0000, 32'h0000_0000};
        vecs[2] = '{32'h0000_2004, 2'd2, 32'h1122_3344, 1'b0, 4'b1111, 32'h1122_3344};
        vecs[3] = '{32'h0000_2002, 2'd1, 32'h0000_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF};
        vecs[4] = '{32'h0000_2000, 2'd1, 32'h1234_5678, 1'b0, 4'b0011, 32'h5678_5678};
        vecs[5] = '{32'h0000_0001, 2'd0, 32'h0000_00A5, 1'b0, 4'b0010, 32'hA5A5_A5A5};
        vecs[6] = '{32'h0000_0002, 2'd2, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h0000_0000};
        vecs[7] = '{32'h0000_0000, 2'd3, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h0000_0000};
        vecs[8] = '{32'h0000_0000, 2'd0, 32'h9988_777F, 1'b0, 4'b0001, 32'h7F7F_7F7F};

        rst = 1'b1;
        st_valid = 1'b0;
        st_addr = '0;
        st_wdata = '0;
        st_size = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        ld_addr = 32'hFFFF_FFF0;

        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_sb_empty", 32'(sb_empty), 32'd1);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_data_req", 32'(data_req), 32'd0);
        check("rst_data_wr", 32'(data_wr), 32'd0);
        check("rst_wstrb", 32'(data_wstrb), 32'd0);
        check("rst_wdata", data_wdata, 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_size", 32'(data_size), 32'd0);
        check("rst_ld_hit", 32'(ld_hit), 32'd0);
        rst = 1'b0;

        // Vector table: one store into an empty buffer, completed in one cycle.
        for (int i = 0; i < 9; i++) begin
            present(vecs[i].addr, vecs[i].size, vecs[i].wdata);
            #1;
            check($sformatf("v%0d_ades", i), 32'(st_ades), 32'(vecs[i].ades));
            @(negedge clk);
            st_valid = 1'b0;
            #1;
            if (!vecs[i].ades) begin
                check($sformatf("v%0d_req", i), 32'(data_req), 32'd1);
                check($sformatf("v%0d_wr", i), 32'(data_wr), 32'd1);
                check($sformatf("v%0d_strb", i), 32'(data_wstrb), 32'(vecs[i].strb));
                check($sformatf("v%0d_wdata", i), data_wdata, vecs[i].data);
                check($sformatf("v%0d_addr", i), data_addr, vecs[i].addr);
                check($sformatf("v%0d_size", i), 32'(data_size), 32'(vecs[i].size));
                data_addr_ok = 1'b1;
                data_data_ok = 1'b1;
                @(negedge clk);
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                #1;
                check($sformatf("v%0d_empty", i), 32'(sb_empty), 32'd1);
                check($sformatf("v%0d_req_done", i), 32'(data_req), 32'd0);
            end else begin
                check($sformatf("v%0d_noreq", i), 32'(data_req), 32'd0);
                check($sformatf("v%0d_noenq", i), 32'(sb_empty), 32'd1);
            end
        end

        // SB via REQ -> WAIT -> done, with in-flight ld_hit.
        present(32'h0000_1003, 2'd0, 32'hAABB_CCDD);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        check("a_req", 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        ld_addr = 32'h0000_1000;
        #1;
        check("a_wait_req", 32'(data_req), 32'd0);
        check("a_wait_empty", 32'(sb_empty), 32'd0);
        check("a_wait_hit", 32'(ld_hit), 32'd1);
        @(negedge clk);
        #1;
        check("a_stray_hold", 32'(data_req), 32'd0);
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        check("a_done_empty", 32'(sb_empty), 32'd1);
        check("a_done_hit", 32'(ld_hit), 32'd0);

        // Fill to DEPTH, hold a fifth store, then drain back-to-back.
        for (int k = 0; k < 4; k++) begin
            present(32'h0000_0100 + 32'(4 * k), 2'd2, 32'(k));
            #1;
            check($sformatf("f_ready%0d", k), 32'(st_ready), 32'd1);
            @(negedge clk);
        end
        st_addr = 32'h0000_0110;
        #1;
        check("f_full", 32'(st_ready), 32'd0);
        check("f_head", data_addr, 32'h0000_0100);
        @(negedge clk);
        #1;
        check("f_full_hold", 32'(st_ready), 32'd0);
        check("f_head_hold", data_addr, 32'h0000_0100);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        check("f_wait_req", 32'(data_req), 32'd0);
        check("f_wait_full", 32'(st_ready), 32'd0);
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        check("f_ready_after_pop", 32'(st_ready), 32'd1);
        check("f_req_next", 32'(data_req), 32'd1);
        check("f_head2", data_addr, 32'h0000_0104);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        check("f_fifth_in", 32'(st_ready), 32'd0);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("d_req%0d", k), 32'(data_req), 32'd1);
            check($sformatf("d_addr%0d", k), data_addr, 32'h0000_0100 + 32'(4 * k));
            @(negedge clk);
            #1;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        check("d_empty", 32'(sb_empty), 32'd1);
        check("d_req_off", 32'(data_req), 32'd0);

        // ld_hit word matching.
        present(32'h0000_3008, 2'd2, 32'hCAFE_F00D);
        @(negedge clk);
        st_valid = 1'b0;
        ld_addr = 32'h0000_300B;
        #1;
        check("h_same_word", 32'(ld_hit), 32'd1);
        ld_addr = 32'h0000_300C;
        #1;
        check("h_next_word", 32'(ld_hit), 32'd0);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        ld_addr = 32'h0000_300B;
        #1;
        check("h_after_done", 32'(ld_hit), 32'd0);

        // Reset while in WAIT with three entries; late data_ok must be ignored.
        for (int k = 0; k < 3; k++) begin
            present(32'h0000_0400 + 32'(4 * k), 2'd2, 32'(k));
            @(negedge clk);
        end
        st_valid = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        ld_addr = 32'h0000_0404;
        #1;
        check("r_wait_req", 32'(data_req), 32'd0);
        check("r_wait_empty", 32'(sb_empty), 32'd0);
        check("r_wait_hit", 32'(ld_hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("r_empty", 32'(sb_empty), 32'd1);
        check("r_req", 32'(data_req), 32'd0);
        check("r_ready", 32'(st_ready), 32'd1);
        check("r_addr", data_addr, 32'd0);
        check("r_hit", 32'(ld_hit), 32'd0);
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        check("r_late_empty", 32'(sb_empty), 32'd1);
        check("r_late_req", 32'(data_req), 32'd0);
        check("r_late_ready", 32'(st_ready), 32'd1);
        present(32'h0000_0500, 2'd1, 32'h0000_ABCD);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        check("r_new_req", 32'(data_req), 32'd1);
        check("r_new_addr", data_addr, 32'h0000_0500);
        check("r_new_strb", 32'(data_wstrb), 32'h3);
        check("r_new_data", data_wdata, 32'hABCD_ABCD);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        check("r_new_empty", 32'(sb_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
